// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the pipelined ARM control path: instruction classes,
// ALU command field values, condition codes, extender selects and the
// control bundle that travels down the E/M/W pipeline.
package arm_ctrl_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int FLAGS_W    = 4;

  // Instruction class, InstructionD[27:26]
  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  // ARM data-processing cmd field, passed straight to the ALU
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Immediate extender selects
  localparam logic [1:0] EXT_IMM8  = 2'b00;
  localparam logic [1:0] EXT_IMM12 = 2'b01;
  localparam logic [1:0] EXT_IMM24 = 2'b10;

  // Bit positions inside the {C,V,N,Z} flag word
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Condition field, InstructionD[31:28]
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Control bundle produced by decode and carried into E.
  // flag_write[1] enables the N,Z update, flag_write[0] the C,V update.
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  branch;
    logic                  link;
    logic                  pc_src;
    logic [1:0]            flag_write;
  } ctrl_t;

  // TST, TEQ, CMP, CMN only set flags and never write a register
  function automatic logic is_compare_cmd(input logic [3:0] cmd);
    return (cmd[3:2] == 2'b10);
  endfunction

  // Commands whose carry/overflow results are meaningful
  function automatic logic is_arith_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_RSB) ||
           (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

endpackage

// File: rtl/pipelined_controller_cond_unit.sv
// Architectural flag register and condition evaluation for the E stage.
// The condition is judged against the stored flags, never the live ALU
// flags, so an instruction directly behind a flag setter sees the new
// flags exactly one cycle later.
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] COND,
  input  logic [3:0] Flags,
  input  logic [1:0] FlagWrite,
  output logic       CondEx
);

  logic [3:0] flag_q;
  logic [3:0] flag_d;
  logic       c_f;
  logic       v_f;
  logic       n_f;
  logic       z_f;

  assign c_f = flag_q[FLAG_C];
  assign v_f = flag_q[FLAG_V];
  assign n_f = flag_q[FLAG_N];
  assign z_f = flag_q[FLAG_Z];

  // Decode the condition field against the stored flags
  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(COND))
      COND_EQ: CondEx = z_f;
      COND_NE: CondEx = ~z_f;
      COND_CS: CondEx = c_f;
      COND_CC: CondEx = ~c_f;
      COND_MI: CondEx = n_f;
      COND_PL: CondEx = ~n_f;
      COND_VS: CondEx = v_f;
      COND_VC: CondEx = ~v_f;
      COND_HI: CondEx = c_f & ~z_f;
      COND_LS: CondEx = ~c_f | z_f;
      COND_GE: CondEx = (n_f == v_f);
      COND_LT: CondEx = (n_f != v_f);
      COND_GT: CondEx = ~z_f & (n_f == v_f);
      COND_LE: CondEx = z_f | (n_f != v_f);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  // Next flag value: each half updates only when enabled and the condition passed
  always_comb begin
    flag_d = flag_q;
    if (FlagWrite[1] && CondEx) begin
      flag_d[1:0] = Flags[1:0];
    end
    if (FlagWrite[0] && CondEx) begin
      flag_d[3:2] = Flags[3:2];
    end
  end

  // Flag register, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 4'b0000;
    end else begin
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/pipelined_controller.sv
// Control path of the pipelined ARM core. Decodes the D-stage instruction
// fields, carries the control bits through private E/M/W registers,
// resolves conditional execution in E and reports pending register/PC
// writes to the hazard unit.
module pipelined_controller
  import arm_ctrl_pkg::*;
#(
  parameter int ALU_W  = 4,
  parameter int FLAG_W = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        OP,
  input  logic [5:0]        FUNCT,
  input  logic [3:0]        COND,
  input  logic [3:0]        Rd,
  input  logic [FLAG_W-1:0] Flags,
  input  logic              FlushE,
  output logic              RA1_select,
  output logic              RA2_select,
  output logic [1:0]        extender_select,
  output logic              shifter_input_select,
  output logic              shifter_amount_select,
  output logic              shifter_type_select,
  output logic              ALUsrcE,
  output logic [ALU_W-1:0]  ALU_control,
  output logic              PC_select_W,
  output logic              data_memory_write_enable,
  output logic              MemtoregW,
  output logic              Register_file_write_enable,
  output logic              PC_select,
  output logic              R14_select,
  output logic              RegWriteM_out,
  output logic              RegWriteW_out,
  output logic              MemtoRegE_out,
  output logic              PCWrPending,
  output logic              BranchTakenE
);

  // ---------------------------------------------------------------- D stage
  ctrl_t      dec_ctrl;
  logic [3:0] cmd;
  logic       s_bit;
  logic       s_eff;

  assign cmd   = FUNCT[4:1];
  assign s_bit = FUNCT[0];

  // Main and ALU decode of the instruction currently in D
  always_comb begin
    dec_ctrl        = '0;
    s_eff           = 1'b0;
    RA1_select      = 1'b0;
    RA2_select      = 1'b0;
    extender_select = EXT_IMM8;
    case (OP)
      OP_DP: begin
        // compare-type commands exist only to set flags, so S is implied
        s_eff               = s_bit | is_compare_cmd(cmd);
        dec_ctrl.reg_write  = ~is_compare_cmd(cmd);
        dec_ctrl.alu_src    = FUNCT[5];
        dec_ctrl.alu_ctrl   = cmd;
        dec_ctrl.flag_write = {s_eff, s_eff & is_arith_cmd(cmd)};
      end
      OP_MEM: begin
        // I=1 means a register offset for memory ops, hence the inversion
        extender_select     = EXT_IMM12;
        dec_ctrl.alu_src    = ~FUNCT[5];
        dec_ctrl.alu_ctrl   = FUNCT[3] ? CMD_ADD : CMD_SUB;
        if (FUNCT[0]) begin
          dec_ctrl.reg_write  = 1'b1;
          dec_ctrl.mem_to_reg = 1'b1;
        end else begin
          dec_ctrl.mem_write  = 1'b1;
          RA2_select          = 1'b1;
        end
      end
      OP_BR: begin
        extender_select   = EXT_IMM24;
        RA1_select        = 1'b1;
        dec_ctrl.branch   = 1'b1;
        dec_ctrl.alu_src  = 1'b1;
        dec_ctrl.alu_ctrl = CMD_ADD;
        dec_ctrl.link     = FUNCT[4];
      end
      default: begin
        dec_ctrl = '0;
      end
    endcase
    // any register write aimed at R15 redirects the PC
    dec_ctrl.pc_src = dec_ctrl.reg_write & (Rd == 4'hF);
  end

  assign shifter_input_select  = 1'b0;
  assign shifter_amount_select = 1'b0;
  assign shifter_type_select   = 1'b0;

  // ---------------------------------------------------------------- E stage
  ctrl_t      ctrl_e_q;
  ctrl_t      ctrl_e_d;
  logic [3:0] cond_e_q;
  logic [3:0] cond_e_d;
  logic       cond_ex_e;

  // A flush turns the incoming E slot into a bubble
  always_comb begin
    ctrl_e_d = dec_ctrl;
    cond_e_d = COND;
    if (FlushE) begin
      ctrl_e_d = '0;
      cond_e_d = 4'b0000;
    end
  end

  // D->E control register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e_q <= '0;
      cond_e_q <= 4'b0000;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      cond_e_q <= cond_e_d;
    end
  end

  cond_unit u_cond_unit (
    .clk       (clk),
    .reset     (reset),
    .COND      (cond_e_q),
    .Flags     (Flags[3:0]),
    .FlagWrite (ctrl_e_q.flag_write),
    .CondEx    (cond_ex_e)
  );

  assign BranchTakenE  = ctrl_e_q.branch & cond_ex_e;
  assign PC_select_W   = BranchTakenE;
  assign ALUsrcE       = ctrl_e_q.alu_src;
  assign ALU_control   = ctrl_e_q.alu_ctrl;
  assign MemtoRegE_out = ctrl_e_q.mem_to_reg;

  // ---------------------------------------------------------------- M stage
  logic reg_write_m_q;
  logic reg_write_m_d;
  logic mem_write_m_q;
  logic mem_write_m_d;
  logic mem_to_reg_m_q;
  logic mem_to_reg_m_d;
  logic pc_src_m_q;
  logic pc_src_m_d;
  logic link_m_q;
  logic link_m_d;

  // Side effects survive into M only if the condition passed in E
  always_comb begin
    reg_write_m_d  = ctrl_e_q.reg_write & cond_ex_e;
    mem_write_m_d  = ctrl_e_q.mem_write & cond_ex_e;
    mem_to_reg_m_d = ctrl_e_q.mem_to_reg;
    pc_src_m_d     = ctrl_e_q.pc_src & cond_ex_e;
    link_m_d       = ctrl_e_q.link & cond_ex_e;
  end

  // E->M control register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      pc_src_m_q     <= 1'b0;
      link_m_q       <= 1'b0;
    end else begin
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      pc_src_m_q     <= pc_src_m_d;
      link_m_q       <= link_m_d;
    end
  end

  assign data_memory_write_enable = mem_write_m_q;
  assign RegWriteM_out            = reg_write_m_q;

  // ---------------------------------------------------------------- W stage
  logic reg_write_w_q;
  logic mem_to_reg_w_q;
  logic pc_src_w_q;
  logic link_w_q;

  // M->W control register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      pc_src_w_q     <= 1'b0;
      link_w_q       <= 1'b0;
    end else begin
      reg_write_w_q  <= reg_write_m_q;
      mem_to_reg_w_q <= mem_to_reg_m_q;
      pc_src_w_q     <= pc_src_m_q;
      link_w_q       <= link_m_q;
    end
  end

  assign MemtoregW                  = mem_to_reg_w_q;
  assign Register_file_write_enable = reg_write_w_q;
  assign RegWriteW_out              = reg_write_w_q;
  assign PC_select                  = pc_src_w_q;
  assign R14_select                 = link_w_q;

  // A PC write is in flight while any of D, E or M carries one
  assign PCWrPending = dec_ctrl.pc_src | ctrl_e_q.pc_src | pc_src_m_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller: a decode/pipeline vector table
// streamed back to back, then hand sequences for condition codes, flag
// forwarding timing, reset and flush corner cases.
module tb_pipelined_controller;

  logic       clk;
  logic       reset;
  logic [1:0] OP;
  logic [5:0] FUNCT;
  logic [3:0] COND;
  logic [3:0] Rd;
  logic [3:0] Flags;
  logic       FlushE;
  logic       RA1_select;
  logic       RA2_select;
  logic [1:0] extender_select;
  logic       shifter_input_select;
  logic       shifter_amount_select;
  logic       shifter_type_select;
  logic       ALUsrcE;
  logic [3:0] ALU_control;
  logic       PC_select_W;
  logic       data_memory_write_enable;
  logic       MemtoregW;
  logic       Register_file_write_enable;
  logic       PC_select;
  logic       R14_select;
  logic       RegWriteM_out;
  logic       RegWriteW_out;
  logic       MemtoRegE_out;
  logic       PCWrPending;
  logic       BranchTakenE;

  pipelined_controller dut (
    .clk                        (clk),
    .reset                      (reset),
    .OP                         (OP),
    .FUNCT                      (FUNCT),
    .COND                       (COND),
    .Rd                         (Rd),
    .Flags                      (Flags),
    .FlushE                     (FlushE),
    .RA1_select                 (RA1_select),
    .RA2_select                 (RA2_select),
    .extender_select            (extender_select),
    .shifter_input_select       (shifter_input_select),
    .shifter_amount_select      (shifter_amount_select),
    .shifter_type_select        (shifter_type_select),
    .ALUsrcE                    (ALUsrcE),
    .ALU_control                (ALU_control),
    .PC_select_W                (PC_select_W),
    .data_memory_write_enable   (data_memory_write_enable),
    .MemtoregW                  (MemtoregW),
    .Register_file_write_enable (Register_file_write_enable),
    .PC_select                  (PC_select),
    .R14_select                 (R14_select),
    .RegWriteM_out              (RegWriteM_out),
    .RegWriteW_out              (RegWriteW_out),
    .MemtoRegE_out              (MemtoRegE_out),
    .PCWrPending                (PCWrPending),
    .BranchTakenE               (BranchTakenE)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every output that is not decode-driven, packed for reset checks
  function automatic logic [15:0] staged_outs();
    return {1'b0, ALUsrcE, ALU_control, PC_select_W, data_memory_write_enable,
            MemtoregW, Register_file_write_enable, PC_select, R14_select,
            RegWriteM_out, RegWriteW_out, MemtoRegE_out, BranchTakenE};
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic issue(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] cond,
                       input logic [3:0] rd, input logic [3:0] flags, input logic flush);
    @(posedge clk);
    #1;
    OP     = op;
    FUNCT  = funct;
    COND   = cond;
    Rd     = rd;
    Flags  = flags;
    FlushE = flush;
  endtask

  task automatic nop();
    issue(2'b11, 6'b000000, 4'hE, 4'h0, 4'h0, 1'b0);
  endtask

  // ---------------------------------------------------------------- vectors
  // d_exp = {RA1,RA2,ext[1:0],sh_in,sh_amt,sh_type}
  // e_exp = {ALUsrcE,ALU_control[3:0],MemtoRegE_out,BranchTakenE}
  // m_exp = {data_memory_write_enable,RegWriteM_out}
  // w_exp = {MemtoregW,Register_file_write_enable,RegWriteW_out,PC_select,R14_select}
  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [6:0] d_exp;
    logic [6:0] e_exp;
    logic [1:0] m_exp;
    logic [4:0] w_exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vec[NV];

  logic [3:0]  fset[5];
  logic [15:0] fmask[5];
  logic [4:0]  w_exp;
  logic        b_exp;

  initial begin
    // ADD R1,R2,R3
    vec[0]  = '{2'b00, 6'b001000, 4'd1, 7'b0000000, 7'b0_0100_0_0, 2'b01, 5'b01100};
    // SUB R2,#imm
    vec[1]  = '{2'b00, 6'b100100, 4'd2, 7'b0000000, 7'b1_0010_0_0, 2'b01, 5'b01100};
    // ORR R3
    vec[2]  = '{2'b00, 6'b011000, 4'd3, 7'b0000000, 7'b0_1100_0_0, 2'b01, 5'b01100};
    // LDR R4, imm offset, U=1
    vec[3]  = '{2'b01, 6'b011001, 4'd4, 7'b0001000, 7'b1_0100_1_0, 2'b01, 5'b11100};
    // STR, imm offset, U=0
    vec[4]  = '{2'b01, 6'b010000, 4'd5, 7'b0101000, 7'b1_0010_0_0, 2'b10, 5'b00000};
    // STR, register offset, U=1
    vec[5]  = '{2'b01, 6'b111000, 4'd6, 7'b0101000, 7'b0_0100_0_0, 2'b10, 5'b00000};
    // B
    vec[6]  = '{2'b10, 6'b100000, 4'd0, 7'b1010000, 7'b1_0100_0_1, 2'b00, 5'b00000};
    // OP=11 does nothing whatever FUNCT holds
    vec[7]  = '{2'b11, 6'b111111, 4'd7, 7'b0000000, 7'b0_0000_0_0, 2'b00, 5'b00000};
    // MOV R5,#imm
    vec[8]  = '{2'b00, 6'b111010, 4'd5, 7'b0000000, 7'b1_1101_0_0, 2'b01, 5'b01100};
    // BL
    vec[9]  = '{2'b10, 6'b010000, 4'd0, 7'b1010000, 7'b1_0100_0_1, 2'b00, 5'b00001};
    // CMN without S: still no register write
    vec[10] = '{2'b00, 6'b010110, 4'd8, 7'b0000000, 7'b0_1011_0_0, 2'b00, 5'b00000};
    // LDR, register offset, U=0
    vec[11] = '{2'b01, 6'b100001, 4'd9, 7'b0001000, 7'b0_0010_1_0, 2'b01, 5'b11100};

    // flag word {C,V,N,Z} and the set of conditions (bit k = cond k) that hold
    fset[0] = 4'b0000; fmask[0] = 16'h56AA;
    fset[1] = 4'b1001; fmask[1] = 16'h66A5;
    fset[2] = 4'b0110; fmask[2] = 16'h565A;
    fset[3] = 4'b0010; fmask[3] = 16'h6A9A;
    fset[4] = 4'b1000; fmask[4] = 16'h55A6;

    // ---------------- reset state
    reset  = 1'b0;
    OP     = 2'b10;
    FUNCT  = 6'b100000;
    COND   = 4'hE;
    Rd     = 4'h0;
    Flags  = 4'h0;
    FlushE = 1'b0;
    #12;
    chk("reset_staged_outs", staged_outs(), 16'h0000);
    chk("reset_pcwr", {15'b0, PCWrPending}, 16'h0000);
    chk("reset_d_follows", {14'b0, RA1_select, extender_select[1]}, 16'h0003);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- table, streamed back to back
    for (int i = 0; i < NV + 3; i++) begin
      if (i < NV) begin
        issue(vec[i].op, vec[i].funct, 4'hE, vec[i].rd, 4'h0, 1'b0);
        exp_q.push_back(vec[i].w_exp);
      end else begin
        nop();
      end
      @(negedge clk);
      if (i < NV) begin
        chk($sformatf("vec%0d_D", i),
            {9'b0, RA1_select, RA2_select, extender_select, shifter_input_select,
             shifter_amount_select, shifter_type_select}, {9'b0, vec[i].d_exp});
      end
      if (i >= 1 && i <= NV) begin
        chk($sformatf("vec%0d_E", i - 1),
            {9'b0, ALUsrcE, ALU_control, MemtoRegE_out, BranchTakenE}, {9'b0, vec[i-1].e_exp});
      end
      if (i >= 2 && i <= NV + 1) begin
        chk($sformatf("vec%0d_M", i - 2),
            {14'b0, data_memory_write_enable, RegWriteM_out}, {14'b0, vec[i-2].m_exp});
      end
      if (i >= 3) begin
        w_exp = exp_q.pop_front();
        chk($sformatf("vec%0d_W", i - 3),
            {11'b0, MemtoregW, Register_file_write_enable, RegWriteW_out, PC_select, R14_select},
            {11'b0, w_exp});
      end
    end

    // ---------------- every condition code against several flag words
    for (int s = 0; s < 5; s++) begin
      issue(2'b00, 6'b010101, 4'hE, 4'h0, fset[s], 1'b0);  // CMP, flags live in its E cycle
      for (int k = 0; k <= 16; k++) begin
        if (k < 16) begin
          issue(2'b10, 6'b100000, k[3:0], 4'h0, fset[s], 1'b0);
        end else begin
          nop();
        end
        @(negedge clk);
        if (k >= 1) begin
          b_exp = fmask[s][k-1];
          chk($sformatf("cond_f%0h_c%0h", fset[s], k - 1),
              {14'b0, PC_select_W, BranchTakenE}, {14'b0, b_exp, b_exp});
        end
      end
    end

    // ---------------- ORRS updates N,Z only; C,V keep their old value
    issue(2'b00, 6'b010101, 4'hE, 4'h0, 4'h0, 1'b0);     // CMP
    issue(2'b00, 6'b011001, 4'hE, 4'h3, 4'hF, 1'b0);     // ORRS, CMP sees 1111
    issue(2'b10, 6'b100000, 4'h2, 4'h0, 4'h0, 1'b0);     // BCS, ORRS sees 0000
    issue(2'b10, 6'b100000, 4'h0, 4'h0, 4'h0, 1'b0);     // BEQ
    @(negedge clk);
    chk("orrs_bcs", {15'b0, BranchTakenE}, 16'h0001);
    issue(2'b10, 6'b100000, 4'h6, 4'h0, 4'h0, 1'b0);     // BVS
    @(negedge clk);
    chk("orrs_beq", {15'b0, BranchTakenE}, 16'h0000);
    issue(2'b10, 6'b100000, 4'h4, 4'h0, 4'h0, 1'b0);     // BMI
    @(negedge clk);
    chk("orrs_bvs", {15'b0, BranchTakenE}, 16'h0001);
    nop();
    @(negedge clk);
    chk("orrs_bmi", {15'b0, BranchTakenE}, 16'h0000);

    // ---------------- CMP sets Z, ADDEQ directly behind it writes, ADDNE does not
    issue(2'b00, 6'b010101, 4'hE, 4'h0, 4'h0, 1'b0);     // CMP
    issue(2'b00, 6'b001000, 4'h0, 4'h1, 4'h1, 1'b0);     // ADDEQ, CMP sees Z
    issue(2'b00, 6'b001000, 4'h1, 4'h2, 4'h0, 1'b0);     // ADDNE
    nop();
    @(negedge clk);
    chk("addeq_M_regwrite", {15'b0, RegWriteM_out}, 16'h0001);
    nop();
    @(negedge clk);
    chk("addeq_W_regwrite", {14'b0, Register_file_write_enable, MemtoregW}, 16'h0002);
    chk("addne_M_regwrite", {15'b0, RegWriteM_out}, 16'h0000);
    nop();
    @(negedge clk);
    chk("addne_W_regwrite", {15'b0, Register_file_write_enable}, 16'h0000);

    // ---------------- TST without S still sets Z and never writes a register
    issue(2'b00, 6'b010000, 4'hE, 4'h0, 4'h0, 1'b0);     // TST
    issue(2'b10, 6'b100000, 4'h0, 4'h0, 4'h1, 1'b0);     // BEQ, TST sees Z
    nop();
    @(negedge clk);
    chk("tst_beq_taken", {15'b0, BranchTakenE}, 16'h0001);
    chk("tst_M_regwrite", {15'b0, RegWriteM_out}, 16'h0000);

    // ---------------- reset mid-stream with a STR in M and an ADD in W
    issue(2'b00, 6'b001000, 4'hE, 4'h1, 4'h0, 1'b0);     // ADD
    issue(2'b01, 6'b011000, 4'hE, 4'h2, 4'h0, 1'b0);     // STR
    nop();
    nop();
    @(negedge clk);
    chk("pre_reset_memwrite", {15'b0, data_memory_write_enable}, 16'h0001);
    chk("pre_reset_rfwe", {15'b0, Register_file_write_enable}, 16'h0001);
    #1;
    reset  = 1'b0;
    FlushE = 1'b1;
    OP     = 2'b10;
    FUNCT  = 6'b100000;
    #1;
    chk("async_reset_memwrite", {15'b0, data_memory_write_enable}, 16'h0000);
    chk("async_reset_rfwe", {15'b0, Register_file_write_enable}, 16'h0000);
    chk("async_reset_staged", staged_outs(), 16'h0000);
    chk("async_reset_d_follows", {15'b0, RA1_select}, 16'h0001);
    @(negedge clk);
    reset  = 1'b1;
    FlushE = 1'b0;
    // FlagReg cleared: EQ must now fail
    issue(2'b00, 6'b001000, 4'h0, 4'h1, 4'h0, 1'b0);     // ADDEQ
    nop();
    nop();
    nop();
    @(negedge clk);
    chk("post_reset_addeq_W", {15'b0, Register_file_write_enable}, 16'h0000);
    issue(2'b10, 6'b010000, 4'h0, 4'h0, 4'h0, 1'b0);     // BLEQ
    nop();
    @(negedge clk);
    chk("bleq_E", {14'b0, PC_select_W, BranchTakenE}, 16'h0000);
    nop();
    nop();
    @(negedge clk);
    chk("bleq_W_link", {15'b0, R14_select}, 16'h0000);

    // ---------------- MOV R15: pending for D, E, M then PC_select in W
    issue(2'b00, 6'b011010, 4'hE, 4'hF, 4'h0, 1'b0);
    @(negedge clk);
    chk("movpc_pend_D", {15'b0, PCWrPending}, 16'h0001);
    nop();
    @(negedge clk);
    chk("movpc_pend_E", {14'b0, PCWrPending, PC_select}, 16'h0002);
    nop();
    @(negedge clk);
    chk("movpc_pend_M", {14'b0, PCWrPending, PC_select}, 16'h0002);
    nop();
    @(negedge clk);
    chk("movpc_W", {13'b0, PCWrPending, PC_select, Register_file_write_enable}, 16'h0003);

    // ---------------- same with FlushE in its D cycle
    issue(2'b00, 6'b011010, 4'hE, 4'hF, 4'h0, 1'b1);
    @(negedge clk);
    chk("flush_pend_D", {15'b0, PCWrPending}, 16'h0001);
    nop();
    @(negedge clk);
    chk("flush_pend_E", {15'b0, PCWrPending}, 16'h0000);
    nop();
    nop();
    @(negedge clk);
    chk("flush_W", {14'b0, PC_select, Register_file_write_enable}, 16'h0000);

    // ---------------- report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
